// File: rtl/sr_driver_pkg.sv
// Shared types and constants for the SR latch driver.
package sr_driver_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StSettle,
    StCheck,
    StDone,
    StErr
  } state_e;

  // SR commands, ordered {s, r}
  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_RST  = 2'b01;
  localparam logic [1:0] SR_SET  = 2'b10;
  localparam logic [1:0] SR_BAD  = 2'b11;

  localparam int unsigned RETRY_W = 3;
  localparam int unsigned TIMER_W = 4;

  // Command that drives the latch towards the target value
  function automatic logic [1:0] sr_drive_cmd(input logic target);
    return target ? SR_SET : SR_RST;
  endfunction

endpackage

// File: rtl/sr_driver_timer.sv
// Loadable down-counter timing the DRIVE and SETTLE phases; holds at zero.
module sr_driver_timer
  import sr_driver_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               zero
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise count down until zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sr_driver.sv
// SR latch write driver: pulses s or r, lets the latch settle, optionally
// verifies the readback and retries. Readback/retry/ERR are built only when
// SR_DRIVER_READBACK_EN is defined.
module sr_driver
  import sr_driver_pkg::*;
#(
  parameter int unsigned PULSE_CYC  = 2,
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_data,
  input  logic q_fb,
  output logic s,
  output logic r,
  output logic done,
  output logic err
);

  // Timer counts down to zero, so load duration minus one
  localparam logic [TIMER_W-1:0] PulseLoad  = TIMER_W'(PULSE_CYC - 1);
  localparam logic [TIMER_W-1:0] SettleLoad = TIMER_W'(SETTLE_CYC - 1);

  state_e             state_q, state_d;
  logic               target_q, target_d;
  logic               timer_load, timer_zero;
  logic [TIMER_W-1:0] timer_val;
  logic [1:0]         sr_cmd;
  logic               accept;

`ifdef SR_DRIVER_READBACK_EN
  logic [RETRY_W-1:0] retry_q, retry_d;
`else
  logic               unused_q_fb;
  logic [RETRY_W-1:0] unused_retry_cfg;
  assign unused_q_fb      = q_fb;
  assign unused_retry_cfg = RETRY_W'(MAX_RETRY);
`endif

  assign req_ready = (state_q == StIdle) && !reset;
  assign accept    = req_valid && req_ready;

  // Never let the forbidden s=r=1 reach the pins
  assign {s, r} = (sr_cmd == SR_BAD) ? SR_HOLD : sr_cmd;

  // Next-state, timer control and outputs
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    timer_load = 1'b0;
    timer_val  = '0;
    sr_cmd     = SR_HOLD;
    done       = 1'b0;
    err        = 1'b0;
`ifdef SR_DRIVER_READBACK_EN
    retry_d    = retry_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          target_d   = req_data;
          timer_load = 1'b1;
          timer_val  = PulseLoad;
          state_d    = StDrive;
`ifdef SR_DRIVER_READBACK_EN
          retry_d    = '0;
`endif
        end
      end
      StDrive: begin
        sr_cmd = sr_drive_cmd(target_q);
        if (timer_zero) begin
          timer_load = 1'b1;
          timer_val  = SettleLoad;
          state_d    = StSettle;
        end
      end
      StSettle: begin
        if (timer_zero) begin
`ifdef SR_DRIVER_READBACK_EN
          state_d = StCheck;
`else
          state_d = StDone;
`endif
        end
      end
      StCheck: begin
`ifdef SR_DRIVER_READBACK_EN
        if (q_fb == target_q) begin
          state_d = StDone;
        end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
          retry_d    = retry_q + 1'b1;
          timer_load = 1'b1;
          timer_val  = PulseLoad;
          state_d    = StDrive;
        end else begin
          state_d = StErr;
        end
`else
        state_d = StIdle;
`endif
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      StErr: begin
`ifdef SR_DRIVER_READBACK_EN
        done = 1'b1;
        err  = 1'b1;
`endif
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      target_q <= 1'b0;
`ifdef SR_DRIVER_READBACK_EN
      retry_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
`ifdef SR_DRIVER_READBACK_EN
      retry_q  <= retry_d;
`endif
    end
  end

  sr_driver_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

endmodule

// File: tb/tb_sr_driver.sv
// Self-checking bench for sr_driver (P=2, S=1, MAX_RETRY=3). Expectations
// follow SR_DRIVER_READBACK_EN when it is defined for the compile.
module tb_sr_driver;

`ifdef SR_DRIVER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam int P  = 2;
  localparam int S  = 1;
  localparam int MR = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic req_data = 1'b0;
  logic req_ready, q_fb, s, r, done, err;

  // 0: model latch, 1: stuck at 0, 2: stuck at 1
  int   fb_mode = 0;
  logic latch_q = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   sr_bad_seen = 1'b0;

  typedef struct {
    int   cyc;
    logic err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (s) latch_q <= 1'b1;
    else if (r) latch_q <= 1'b0;
  end

  assign q_fb = (fb_mode == 1) ? 1'b0 : (fb_mode == 2) ? 1'b1 : latch_q;

  sr_driver #(
    .PULSE_CYC  (P),
    .SETTLE_CYC (S),
    .MAX_RETRY  (MR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .q_fb      (q_fb),
    .s         (s),
    .r         (r),
    .done      (done),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Illegal command watch plus done/err scoreboard
  always @(negedge clk) begin
    assert (!(s && r)) else $error("s and r both high");
    if (s && r) sr_bad_seen = 1'b1;
    if (done) begin
      if (sb.size() == 0) begin
        chk("done_spurious", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("err_value", err, e.err);
      end
    end else if (err) begin
      chk("err_without_done", 1, 0);
    end
  end

  // One request: model computes attempts, s/r per cycle and done cycle
  task automatic run_req(input logic data, input int mode, input bit hold);
    int   n;
    int   c0;
    int   period;
    int   attempts;
    int   done_c;
    bit   match;
    logic errx;
    logic exp_s, exp_r;
    fb_mode = mode;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    match    = (mode == 0) || (mode == 1 && data == 1'b0) || (mode == 2 && data == 1'b1);
    attempts = (RB && !match) ? MR + 1 : 1;
    errx     = RB && !match;
    period   = P + S + (RB ? 1 : 0);
    done_c   = attempts * period + 1;
    c0       = cyc;
    req_valid = 1'b1;
    req_data  = data;
    sb.push_back('{cyc: c0 + done_c, err: errx});
    for (int k = 1; k <= done_c + 1; k++) begin
      @(negedge clk);
      if (hold) begin
        req_data = ~req_data;
        if (k >= done_c) req_valid = 1'b0;
      end else begin
        req_valid = 1'b0;
      end
      if (k <= done_c) begin
        int a;
        int o;
        a = (k - 1) / period;
        o = (k - 1) % period;
        exp_s = (a < attempts && o < P) ? data : 1'b0;
        exp_r = (a < attempts && o < P) ? ~data : 1'b0;
        chk("s_value", s, exp_s);
        chk("r_value", r, exp_r);
        chk("ready_busy", req_ready, 0);
      end else begin
        chk("ready_after", req_ready, 1);
      end
    end
    if (hold) begin
      @(negedge clk);
      chk("no_queued_req", req_ready, 1);
    end
    chk("sb_drain", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int dcnt;
    // Reset held for two cycles
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_s", s, 0);
      chk("rst_r", r, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_ready", req_ready, 0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);

    run_req(1'b1, 0, 1'b0);
    chk("latch_set", q_fb, 1);
    run_req(1'b0, 0, 1'b0);
    chk("latch_rst", q_fb, 0);
    run_req(1'b1, 0, 1'b1);
    run_req(1'b1, 1, 1'b0);
    run_req(1'b1, 2, 1'b0);
    run_req(1'b0, 2, 1'b0);

    // Abort in the second DRIVE cycle
    fb_mode = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_data  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_s_c1", s, 1);
    @(negedge clk);
    chk("abort_s_c2", s, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_s_off", s, 0);
    chk("abort_r_off", r, 0);
    reset = 1'b0;
    dcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || err) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    run_req(1'b0, 0, 1'b0);

    chk("no_sr_bad", sr_bad_seen, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
